dma_ctrl: RTL and testbench
===========================

// Module: dma_ctrl
// PURPOSE
//  Memory-to-memory byte-copy DMA engine for the 65xx SoC. Sits in the IO page
//  beside the CIA/ACIA and is programmed through 8 CPU registers. It steals bus
//  cycles from the CPU by pulling RDY low, then drives address/data to the shared RAM.
//  It raises an IRQ on completion.
// PARAMETERS
//  BURST   16   max bytes moved per bus ownership before one CPU cycle is released (1..255)
// PORTS
//  clk        in   1   system clock
//  reset_n    in   1   reset, synchronous, active-low
//  cs_n       in   1   register chip select (IO subpage decode)
//  cpu_we_n   in   1   CPU write strobe; also marks CPU read cycles for hand-off
//  rs         in   3   register select (CPU_AB[2:0])
//  din        in   8   CPU write data
//  dout       out  8   register read data, registered (valid cycle after address)
//  irq_n      out  1   completion interrupt, active-low
//  cpu_rdy    out  1   CPU RDY; 0 while DMA owns the bus
//  dma_own    out  1   1 = address/data mux selects DMA outputs
//  dma_addr   out  16  DMA memory address
//  dma_we_n   out  1   DMA write strobe, active-low
//  dma_do     out  8   DMA write data
//  mem_di     in   8   memory read data, 1-cycle synchronous latency
// BEHAVIOUR
//  Registers: 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H, 4 LEN_L, 5 LEN_H
//   6 CTRL:  wr bit0=START, bit1=IRQ_EN
//            rd {BUSY,DONE,4'b0,IRQ_EN,1'b0}
//   7 STAT:  wr any value clears DONE
//            rd remaining LEN_L
//  Writes happen on clk when cs_n=0, cpu_we_n=0, cpu_rdy=1.
//  Writes to regs 0-5, and START, are ignored while BUSY.
//  Reset values: regs=0, DONE=0, IRQ_EN=0, dout=0, irq_n=1, cpu_rdy=1, dma_own=0,
//   dma_we_n=1, dma_addr=0, dma_do=0, state=IDLE.
//  FSM: IDLE -> REQ -> RD -> WR -> (RD | REL) -> (REQ | IDLE).
//  - IDLE: START with LEN!=0 -> REQ, BUSY=1. START with LEN=0 -> DONE=1, stays
//    IDLE, no bus cycles.
//  - REQ: cpu_rdy=1. Waits for a cycle with cpu_we_n=1 (the 65xx halts only on
//    reads), then -> RD. Never seizes the bus during a CPU write cycle.
//  - RD: cpu_rdy=0, dma_own=1, dma_addr=SRC, dma_we_n=1 -> WR.
//  - WR: dma_addr=DST, dma_do=mem_di, dma_we_n=0. Then SRC+=1, DST+=1, LEN-=1,
//    burst_cnt+=1. If LEN reaches 0 -> REL with DONE pending. Else if
//    burst_cnt==BURST -> REL. Else -> RD.
//  - REL: cpu_rdy=1, dma_own=0 for exactly one cycle. Then -> IDLE (BUSY=0,
//    DONE=1) if LEN==0, else -> REQ with burst_cnt=0.
//  cpu_rdy, dma_own and dma_we_n decode from the state register only (glitch-free).
//  Throughput: 2 clk/byte inside a burst. Overhead per burst: 1 REL + >=1 REQ cycle.
//  SRC/DST are 16-bit and wrap FFFF->0000 with no error. LEN counts down; max 65535.
//  irq_n = ~(DONE & IRQ_EN). Clearing IRQ_EN or DONE deasserts it next cycle.
//  A DONE set and a STAT write in the same cycle: the set wins.
//  A CPU register write cannot coincide with RD/WR (CPU is halted).
//  Reset mid-transfer: next clk returns IDLE, cpu_rdy=1, dma_own=0. A byte already
//   written stays written. No further writes.
// TESTING
//  1 SRC=0x1000, DST=0x2000, LEN=4, START -> RAM[2000..2003]==RAM[1000..1003]; 8 own
//    cycles; DONE=1, BUSY=0, LEN=0.
//  2 LEN=40, BURST=16 -> bursts of 16,16,8. cpu_rdy high exactly 1 cycle (REL) plus
//    REQ wait between bursts.
//  3 START issued while CPU is in a write cycle -> RD entered only after first
//    cpu_we_n=1 cycle; CPU write lands intact.
//  4 SRC=0xFFFE, DST=0x3000, LEN=3 -> reads FFFE, FFFF, 0000; SRC ends at 0x0001.
//  5 IRQ_EN=1, LEN=1 -> irq_n low after REL. STAT write -> irq_n high next cycle.
//    LEN=0 START -> DONE, no dma_own.
//  6 reset_n=0 during burst 2 of LEN=40 -> next cycle cpu_rdy=1, dma_own=0,
//    dma_we_n=1, all regs 0.

Source files
------------

// File: rtl/dma_ctrl.sv
// Memory-to-memory byte-copy DMA, programmed through 8 CPU registers; 2 clk/byte inside a burst.
// Bus is seized only on a CPU read cycle (cpu_rdy low during RD/WR) and released for one cycle every BURST bytes.
module dma_ctrl #(
   parameter int unsigned BURST = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs_n,
   input  logic        cpu_we_n,
   input  logic [2:0]  rs,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   output logic        irq_n,
   output logic        cpu_rdy,
   output logic        dma_own,
   output logic [15:0] dma_addr,
   output logic        dma_we_n,
   output logic [7:0]  dma_do,
   input  logic [7:0]  mem_di
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RD,
      S_WR,
      S_REL
   } state_t;

   localparam logic [7:0] BURST_C = 8'(BURST);

   state_t      state_q, state_d;
   logic [15:0] src_q, src_d;
   logic [15:0] dst_q, dst_d;
   logic [15:0] len_q, len_d;
   logic [7:0]  burst_q, burst_d;
   logic        done_q, done_d;
   logic        irq_en_q, irq_en_d;
   logic [7:0]  dout_q, dout_d;

   logic        busy;
   logic        reg_wr;
   logic        start;
   logic [7:0]  rd_val;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         burst_q  <= '0;
         done_q   <= 1'b0;
         irq_en_q <= 1'b0;
         dout_q   <= '0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         burst_q  <= burst_d;
         done_q   <= done_d;
         irq_en_q <= irq_en_d;
         dout_q   <= dout_d;
      end
   end

   always_comb begin
      busy   = (state_q != S_IDLE);
      reg_wr = !cs_n && !cpu_we_n && cpu_rdy;
      start  = reg_wr && (rs == 3'd6) && din[0] && !busy;

      case (rs)
         3'd0:    rd_val = src_q[7:0];
         3'd1:    rd_val = src_q[15:8];
         3'd2:    rd_val = dst_q[7:0];
         3'd3:    rd_val = dst_q[15:8];
         3'd4:    rd_val = len_q[7:0];
         3'd5:    rd_val = len_q[15:8];
         3'd6:    rd_val = {busy, done_q, 4'b0000, irq_en_q, 1'b0};
         default: rd_val = len_q[7:0];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      burst_d  = burst_q;
      done_d   = done_q;
      irq_en_d = irq_en_q;
      dout_d   = cs_n ? dout_q : rd_val;

      if (reg_wr) begin
         case (rs)
            3'd0: if (!busy) src_d[7:0]  = din;
            3'd1: if (!busy) src_d[15:8] = din;
            3'd2: if (!busy) dst_d[7:0]  = din;
            3'd3: if (!busy) dst_d[15:8] = din;
            3'd4: if (!busy) len_d[7:0]  = din;
            3'd5: if (!busy) len_d[15:8] = din;
            3'd6: irq_en_d = din[1];
            3'd7: done_d   = 1'b0;
         endcase
      end

      // Sequencing comes after the register writes so a completion beats a same-cycle STAT clear.
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len_q != 16'd0) begin
                  state_d = S_REQ;
                  burst_d = 8'd0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_REQ: begin
            if (cpu_we_n) state_d = S_RD;
         end
         S_RD: begin
            state_d = S_WR;
         end
         S_WR: begin
            src_d   = src_q + 16'd1;
            dst_d   = dst_q + 16'd1;
            len_d   = len_q - 16'd1;
            burst_d = burst_q + 8'd1;
            if (len_q == 16'd1)                  state_d = S_REL;
            else if (burst_q + 8'd1 == BURST_C)  state_d = S_REL;
            else                                 state_d = S_RD;
         end
         S_REL: begin
            if (len_q == 16'd0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = S_REQ;
               burst_d = 8'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cpu_rdy  = !((state_q == S_RD) || (state_q == S_WR));
   assign dma_own  = (state_q == S_RD) || (state_q == S_WR);
   assign dma_we_n = (state_q != S_WR);
   assign dma_addr = (state_q == S_RD) ? src_q : ((state_q == S_WR) ? dst_q : 16'h0000);
   assign dma_do   = (state_q == S_WR) ? mem_di : 8'h00;
   assign dout     = dout_q;
   assign irq_n    = !(done_q && irq_en_q);

endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: shared 64 KiB RAM model, directed register programming and a negedge scoreboard
// monitor for DMA reads, DMA writes, burst lengths, inter-burst gaps and register read data.
module tb_dma_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cs_n;
   logic        cpu_we_n;
   logic [2:0]  rs;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        irq_n;
   logic        cpu_rdy;
   logic        dma_own;
   logic [15:0] dma_addr;
   logic        dma_we_n;
   logic [7:0]  dma_do;
   logic [7:0]  mem_di;

   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdat;
   logic        cpu_ram_we;
   logic [7:0]  ram [0:65535];

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_ra[$];
   logic [15:0] exp_wa[$];
   logic [7:0]  exp_wd[$];
   logic [7:0]  exp_dout[$];
   int          exp_run[$];
   int          exp_gap[$];

   always #5 clk = ~clk;

   dma_ctrl #(.BURST(16)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .cs_n     (cs_n),
      .cpu_we_n (cpu_we_n),
      .rs       (rs),
      .din      (din),
      .dout     (dout),
      .irq_n    (irq_n),
      .cpu_rdy  (cpu_rdy),
      .dma_own  (dma_own),
      .dma_addr (dma_addr),
      .dma_we_n (dma_we_n),
      .dma_do   (dma_do),
      .mem_di   (mem_di)
   );

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // RAM: synchronous read with one cycle latency, DMA has priority on the shared bus.
   initial begin
      mem_di = 8'h00;
      for (int i = 0; i < 65536; i++) ram[i] = pat(16'(i));
      forever begin
         @(posedge clk);
         if (dma_own && !dma_we_n)       ram[dma_addr] <= dma_do;
         else if (!dma_own && cpu_ram_we) ram[cpu_addr] <= cpu_wdat;
         mem_di <= ram[dma_own ? dma_addr : cpu_addr];
      end
   end

   // Scoreboard monitor.
   initial begin
      logic rd_pend  = 1'b0;
      logic prev_own = 1'b0;
      logic gap_ok   = 1'b0;
      int   run      = 0;
      int   gap      = 0;
      forever begin
         @(negedge clk);
         if (rd_pend) begin
            if (exp_dout.size() == 0) chk("dout_unexpected", 1, 0);
            else                      chk("dout", dout, exp_dout.pop_front());
         end
         rd_pend = !cs_n && cpu_we_n && reset_n;
         if (dma_own) begin
            chk("rdy_low_when_own", cpu_rdy, 0);
            if (dma_we_n) begin
               if (exp_ra.size() == 0) chk("rd_unexpected", 1, 0);
               else                    chk("rd_addr", dma_addr, exp_ra.pop_front());
            end else begin
               if (exp_wa.size() == 0) chk("wr_unexpected", 1, 0);
               else begin
                  chk("wr_addr", dma_addr, exp_wa.pop_front());
                  chk("wr_data", dma_do, exp_wd.pop_front());
               end
            end
            if (!prev_own) begin
               if (gap_ok) begin
                  if (exp_gap.size() == 0) chk("gap_unexpected", 1, 0);
                  else                     chk("gap_len", gap, exp_gap.pop_front());
               end
               gap_ok = 1'b0;
               run = 1;
            end else begin
               run++;
            end
         end else begin
            if (prev_own) begin
               if (exp_run.size() == 0) chk("run_unexpected", 1, 0);
               else                     chk("own_cycles", run, exp_run.pop_front());
               gap = 1;
               gap_ok = 1'b1;
            end else begin
               gap++;
            end
         end
         if (!cs_n) gap_ok = 1'b0;
         prev_own = dma_own;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
      cs_n = 1'b0; cpu_we_n = 1'b0; rs = a; din = d;
      step();
      cs_n = 1'b1; cpu_we_n = 1'b1;
   endtask

   task automatic reg_rd(input logic [2:0] a, input logic [7:0] e);
      exp_dout.push_back(e);
      cs_n = 1'b0; cpu_we_n = 1'b1; rs = a;
      step();
      cs_n = 1'b1;
   endtask

   task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
      reg_wr(3'd0, s[7:0]);  reg_wr(3'd1, s[15:8]);
      reg_wr(3'd2, d[7:0]);  reg_wr(3'd3, d[15:8]);
      reg_wr(3'd4, n[7:0]);  reg_wr(3'd5, n[15:8]);
   endtask

   task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         exp_ra.push_back(s + 16'(i));
         exp_wa.push_back(d + 16'(i));
         exp_wd.push_back(pat(s + 16'(i)));
      end
   endtask

   task automatic wait_done(input string name, input int budget);
      int quiet = 0;
      int n = 0;
      while (quiet < 6 && n < budget) begin
         @(negedge clk);
         n++;
         if (dma_own) quiet = 0;
         else         quiet++;
      end
      chk(name, n >= budget, 0);
      step();
   endtask

   initial begin
      int   rises;
      int   n;
      logic prev;
      logic own_seen;

      reset_n = 1'b0; cs_n = 1'b1; cpu_we_n = 1'b1; rs = 3'd0; din = 8'h00;
      cpu_addr = 16'h0000; cpu_wdat = 8'h00; cpu_ram_we = 1'b0;
      step(); step();
      chk("rst_cpu_rdy", cpu_rdy, 1);
      chk("rst_dma_own", dma_own, 0);
      chk("rst_dma_we_n", dma_we_n, 1);
      chk("rst_dma_addr", dma_addr, 16'h0000);
      chk("rst_irq_n", irq_n, 1);
      chk("rst_dout", dout, 8'h00);
      reset_n = 1'b1;
      step();

      // Basic 4-byte copy.
      setup(16'h1000, 16'h2000, 16'd4);
      push_copy(16'h1000, 16'h2000, 4);
      exp_run.push_back(8);
      reg_wr(3'd6, 8'h01);
      wait_done("t1_timeout", 200);
      reg_rd(3'd6, 8'h40);
      reg_rd(3'd7, 8'h00);
      reg_rd(3'd5, 8'h00);
      reg_rd(3'd0, 8'h04);
      reg_rd(3'd1, 8'h10);
      reg_rd(3'd3, 8'h20);
      for (int i = 0; i < 4; i++) chk("t1_ram", ram[16'h2000 + 16'(i)], pat(16'h1000 + 16'(i)));

      // 40 bytes in bursts of 16,16,8 with REL+REQ gaps.
      reg_wr(3'd7, 8'h00);
      reg_rd(3'd6, 8'h00);
      setup(16'h1100, 16'h2100, 16'd40);
      push_copy(16'h1100, 16'h2100, 40);
      exp_run.push_back(32); exp_run.push_back(32); exp_run.push_back(16);
      exp_gap.push_back(2);  exp_gap.push_back(2);
      reg_wr(3'd6, 8'h01);
      wait_done("t2_timeout", 500);
      reg_rd(3'd6, 8'h40);
      reg_rd(3'd4, 8'h00);
      reg_rd(3'd0, 8'h28);
      reg_rd(3'd1, 8'h11);
      chk("t2_ram_last", ram[16'h2127], pat(16'h1127));

      // START while the CPU keeps writing: bus held off until a read cycle.
      reg_wr(3'd7, 8'h00);
      setup(16'h1200, 16'h2200, 16'd2);
      push_copy(16'h1200, 16'h2200, 2);
      exp_run.push_back(4);
      reg_wr(3'd6, 8'h01);
      own_seen = 1'b0;
      cpu_we_n = 1'b0; cpu_ram_we = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cpu_addr = 16'h4000 + 16'(i);
         cpu_wdat = 8'hC0 + 8'(i);
         step();
         own_seen = own_seen | dma_own;
      end
      chk("t3_no_seize_on_write", own_seen, 0);
      cpu_we_n = 1'b1; cpu_ram_we = 1'b0; cpu_addr = 16'h0000;
      step();
      chk("t3_seize_after_read", dma_own, 1);
      wait_done("t3_timeout", 200);
      for (int i = 0; i < 3; i++) chk("t3_cpu_write", ram[16'h4000 + 16'(i)], 8'hC0 + 8'(i));
      chk("t3_ram", ram[16'h2201], pat(16'h1201));

      // Source address wrap.
      reg_wr(3'd7, 8'h00);
      setup(16'hFFFE, 16'h3000, 16'd3);
      push_copy(16'hFFFE, 16'h3000, 3);
      exp_run.push_back(6);
      reg_wr(3'd6, 8'h01);
      wait_done("t4_timeout", 200);
      reg_rd(3'd0, 8'h01);
      reg_rd(3'd1, 8'h00);
      reg_rd(3'd2, 8'h03);
      reg_rd(3'd6, 8'h40);
      chk("t4_ram_wrap", ram[16'h3002], pat(16'h0000));

      // Interrupt, STAT clear, zero-length start, set-beats-clear, IRQ_EN clear.
      reg_wr(3'd7, 8'h00);
      reg_wr(3'd6, 8'h02);
      chk("t5_irq_idle", irq_n, 1);
      setup(16'h1300, 16'h2300, 16'd1);
      push_copy(16'h1300, 16'h2300, 1);
      exp_run.push_back(2);
      reg_wr(3'd6, 8'h03);
      chk("t5_irq_busy", irq_n, 1);
      wait_done("t5_timeout", 200);
      chk("t5_irq_done", irq_n, 0);
      reg_rd(3'd6, 8'h42);
      reg_wr(3'd7, 8'h00);
      chk("t5_irq_stat_clr", irq_n, 1);
      reg_wr(3'd6, 8'h03);
      own_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         own_seen = own_seen | dma_own;
      end
      chk("t5_len0_no_own", own_seen, 0);
      chk("t5_len0_irq", irq_n, 0);
      reg_rd(3'd6, 8'h42);
      reg_wr(3'd7, 8'h00);
      setup(16'h1310, 16'h2310, 16'd1);
      push_copy(16'h1310, 16'h2310, 1);
      exp_run.push_back(2);
      reg_wr(3'd6, 8'h03);
      step(); step(); step();
      reg_wr(3'd7, 8'h00);
      chk("t5_set_beats_clr", irq_n, 0);
      reg_rd(3'd6, 8'h42);
      reg_wr(3'd6, 8'h00);
      chk("t5_irq_en_clr", irq_n, 1);
      reg_rd(3'd6, 8'h40);

      // Reset in the middle of burst 2: bytes 0..17 written, byte 18 only read.
      reg_wr(3'd7, 8'h00);
      setup(16'h5000, 16'h6000, 16'd40);
      push_copy(16'h5000, 16'h6000, 18);
      exp_ra.push_back(16'h5012);
      exp_run.push_back(32); exp_run.push_back(5);
      exp_gap.push_back(2);
      reg_wr(3'd6, 8'h01);
      rises = 0; n = 0; prev = 1'b0;
      while (rises < 2 && n < 500) begin
         @(negedge clk);
         n++;
         if (dma_own && !prev) rises++;
         prev = dma_own;
      end
      chk("t6_timeout", n >= 500, 0);
      @(posedge clk); #1;
      step(); step(); step();
      reset_n = 1'b0;
      step();
      chk("t6_rst_cpu_rdy", cpu_rdy, 1);
      chk("t6_rst_dma_own", dma_own, 0);
      chk("t6_rst_dma_we_n", dma_we_n, 1);
      chk("t6_rst_dma_addr", dma_addr, 16'h0000);
      chk("t6_rst_irq_n", irq_n, 1);
      reset_n = 1'b1;
      step();
      for (int i = 0; i < 8; i++) reg_rd(3'(i), 8'h00);
      step(); step();
      chk("t6_ram_written", ram[16'h6011], pat(16'h5011));
      chk("t6_ram_untouched", ram[16'h6012], pat(16'h6012));

      chk("left_rd", exp_ra.size(), 0);
      chk("left_wr", exp_wa.size(), 0);
      chk("left_dout", exp_dout.size(), 0);
      chk("left_run", exp_run.size(), 0);
      chk("left_gap", exp_gap.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
